imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the byte-addressed instruction memory. Accepts a framed
//  byte stream (valid/ready), assembles it into little-endian instruction bytes
//  and issues one-byte write strobes to the imem write port. Holds the core in
//  reset while loading; frame = LEN[4 bytes, LSB first] + LEN payload bytes + CSUM.
// PARAMETERS
//  ADDR_W     12     width of wr_addr (byte address)
//  MEM_BYTES  2048   instruction memory size in bytes
//  BASE_ADDR  0      byte address of the first payload byte
//  TIMEOUT    65535  idle cycles allowed between accepted bytes inside a frame
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse: begin receiving a frame
//  in_valid   in   1       stream byte valid
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts a byte when in_valid&in_ready
//  wr_en      out  1       imem byte write strobe
//  wr_addr    out  ADDR_W  imem byte address
//  wr_data    out  8       imem byte data
//  cpu_hold   out  1       1 = core held in reset (loading in progress or error)
//  done       out  1       frame loaded and checksum good (sticky)
//  err        out  1       length overflow, bad checksum or timeout (sticky)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; in_ready, wr_en, cpu_hold, done, err = 0;
//    wr_addr, wr_data, length, byte index, checksum, timeout counter = 0.
//  - Byte accepted only on in_valid&in_ready at a rising clk edge.
//  - FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
//  - IDLE/DONE/ERR: in_ready=0. start=1 -> LEN; clears done, err, idx, sum,
//    timeout counter; cpu_hold=1 from the next cycle.
//  - start while in LEN/DATA/CSUM is ignored.
//  - LEN: in_ready=1; k-th accepted byte (k=0..3) -> len[8k+:8]. After 4th byte:
//    len==0 -> CSUM; len > MEM_BYTES-BASE_ADDR -> ERR; else DATA.
//  - DATA: in_ready=1; each accepted byte b at index i (0..len-1): next cycle
//    wr_en=1 for exactly one cycle, wr_addr=BASE_ADDR+i (ADDR_W bits),
//    wr_data=b; sum=(sum+b) mod 256. Byte with i==len-1 -> CSUM. Back-to-back
//    bytes give back-to-back strobes (1-cycle latency, no bubbles).
//  - CSUM: in_ready=1; accepted byte == sum -> DONE, else ERR. Checksum byte is
//    never written to memory.
//  - DONE: cpu_hold=0, done=1. ERR: cpu_hold=1, err=1 (core stays held).
//  - Timeout: in LEN/DATA/CSUM counter increments each cycle with no accepted
//    byte, clears on accept; reaching TIMEOUT -> ERR. Writes already issued remain.
//  - wr_en never asserted outside the cycle after a DATA accept.
//  - Reset mid-frame: abort immediately, all outputs to reset values, no further
//    strobes; partially written memory content is not restored.
// TESTING
//  1 Frame len=4, bytes 13 05 00 00, csum 0x18 -> wr_en x4, addr 0..3, data
//    13,05,00,00 in order; done=1, cpu_hold=0, err=0.
//  2 Same frame with csum 0x19 -> four writes issued, then err=1, cpu_hold=1,
//    done=0.
//  3 len=0x00000801 with MEM_BYTES=2048 -> ERR right after 4th length byte, zero
//    wr_en pulses.
//  4 len=0, csum 0x00 -> DONE, no writes; csum 0x01 -> ERR.
//  5 TIMEOUT=16, stall in_valid 16 cycles after 2 payload bytes -> err=1,
//    exactly 2 writes seen; start then resends full frame -> done=1.
//  6 rst low while in DATA after 3 bytes -> outputs zero same cycle; no strobe
//    after release; in_valid held high with in_ready=0 until next start.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time framed byte-stream loader for the instruction memory
//
// Receives LEN (4 bytes, LSB first) + LEN payload bytes + 8-bit additive checksum,
// writes each payload byte to imem one cycle after it is accepted, and keeps the
// core in reset until a good frame has been loaded.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   start                  1-cycle pulse, begins a frame from IDLE/DONE/ERR
//   in_valid/in_data/in_ready   byte stream handshake
//   wr_en/wr_addr/wr_data  imem byte write port
//   cpu_hold               core held in reset (loading or error)
//   done/err               sticky frame status
module imem_loader #(
   parameter int ADDR_W    = 12,
   parameter int MEM_BYTES = 2048,
   parameter int BASE_ADDR = 0,
   parameter int TIMEOUT   = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam int              TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [31:0]     LIMIT   = 32'(MEM_BYTES - BASE_ADDR);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t           state, state_n;
   logic [31:0]      len;
   logic [31:0]      idx;
   logic [7:0]       sum;
   logic [TO_W-1:0]  tcnt;
   logic             active;
   logic             acc;
   logic             timeout;
   logic [31:0]      full_len;

   assign active   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
   assign acc      = in_valid && active;
   // Fires on the idle cycle that would bring the counter to TIMEOUT.
   assign timeout  = active && !acc && (tcnt == TO_LAST);
   // Length as it will be once the 4th (MSB) byte currently on the bus lands.
   assign full_len = {in_data, len[23:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_n = S_LEN;
         end
         S_LEN: begin
            if (timeout) state_n = S_ERR;
            else if (acc && idx == 32'd3) begin
               if (full_len == 32'd0)    state_n = S_CSUM;
               else if (full_len > LIMIT) state_n = S_ERR;
               else                       state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (timeout) state_n = S_ERR;
            else if (acc && idx == len - 32'd1) state_n = S_CSUM;
         end
         S_CSUM: begin
            if (timeout)  state_n = S_ERR;
            else if (acc) state_n = (in_data == sum) ? S_DONE : S_ERR;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = active;
      cpu_hold = active || (state == S_ERR);
      done     = (state == S_DONE);
      err      = (state == S_ERR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         len     <= '0;
         idx     <= '0;
         sum     <= '0;
         tcnt    <= '0;
      end else begin
         wr_en <= 1'b0;
         if (!active && start) begin
            len  <= '0;
            idx  <= '0;
            sum  <= '0;
            tcnt <= '0;
         end else if (active) begin
            tcnt <= acc ? '0 : tcnt + 1'b1;
            if (acc) begin
               case (state)
                  S_LEN: begin
                     len[{idx[1:0], 3'b000} +: 8] <= in_data;
                     // idx restarts so it becomes the payload index in DATA.
                     idx <= (idx == 32'd3) ? '0 : idx + 32'd1;
                  end
                  S_DATA: begin
                     wr_en   <= 1'b1;
                     wr_addr <= ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];
                     wr_data <= in_data;
                     sum     <= sum + in_data;
                     idx     <= idx + 32'd1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   localparam int ADDR_W    = 12;
   localparam int MEM_BYTES = 2048;
   localparam int BASE_ADDR = 0;
   localparam int TIMEOUT   = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              cpu_hold;
   logic              done;
   logic              err;

   int total = 0;
   int bad   = 0;

   // Expected strobe for the coming negedge, posted by the driver when a payload byte is taken.
   logic        due = 1'b0;
   logic [31:0] due_addr = 0;
   logic [7:0]  due_data = 0;
   int          wr_count = 0;

   logic [7:0]  pl [16];

   imem_loader #(
      .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: frame outcome from its contents alone.
   function automatic logic [7:0] psum(input logic [31:0] n);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 16; i++) if (i < n) s = s + pl[i];
      return s;
   endfunction

   function automatic logic model_done(input logic [31:0] n, input logic [7:0] cs);
      return (n <= 32'(MEM_BYTES - BASE_ADDR)) && (cs == psum(n));
   endfunction

   // Compare process: every cycle a strobe appears exactly when the model expects one.
   initial begin
      forever begin
         @(negedge clk);
         if (due) begin
            chk("wr_en", {31'd0, wr_en}, 32'd1);
            chk("wr_addr", {20'd0, wr_addr}, due_addr);
            chk("wr_data", {24'd0, wr_data}, {24'd0, due_data});
            wr_count++;
            due = 1'b0;
         end else begin
            chk("no_strobe", {31'd0, wr_en}, 32'd0);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
      chk("ready_after_start", {31'd0, in_ready}, 32'd1);
      chk("flags_cleared", {30'd0, done, err}, 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic is_pay, input int i);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 4) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready", {31'd0, in_ready}, 32'd1);
      if (in_ready) begin
         @(posedge clk);
         if (is_pay) begin
            due      = 1'b1;
            due_addr = 32'(BASE_ADDR + i);
            due_data = b;
         end
      end
   endtask

   // Sends start, length, the first npay payload bytes and, if the payload is complete, csum.
   task automatic send_frame(input logic [31:0] n, input logic [7:0] cs, input int npay);
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b0, 0);
      if (n > 32'(MEM_BYTES - BASE_ADDR)) return;
      for (int i = 0; i < npay; i++) send_byte(pl[i], 1'b1, i);
      if (npay < int'(n)) return;
      send_byte(cs, 1'b0, 0);
   endtask

   task automatic end_frame(input logic exp_done);
      @(negedge clk);
      in_valid = 1'b0;
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("err", {31'd0, err}, {31'd0, !exp_done});
      chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
      chk("ready_idle", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic run_frame(input logic [31:0] n, input logic [7:0] cs, input int exp_writes);
      wr_count = 0;
      send_frame(n, cs, int'(n));
      end_frame(model_done(n, cs));
      chk("write_count", wr_count, exp_writes);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #12;
      chk("rst_outputs", {in_ready, wr_en, cpu_hold, done, err}, 32'd0);
      chk("rst_wr", {12'd0, wr_addr, wr_data}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: good 4-byte frame
      pl[0] = 8'h13; pl[1] = 8'h05; pl[2] = 8'h00; pl[3] = 8'h00;
      chk("model_sum", {24'd0, psum(4)}, 32'h18);
      run_frame(32'd4, 8'h18, 4);
      chk("t1_done", {29'd0, done, err, cpu_hold}, 32'b100);

      // 2: bad checksum, writes still issued
      run_frame(32'd4, 8'h19, 4);
      chk("t2_err", {29'd0, done, err, cpu_hold}, 32'b011);

      // Distinct pattern exercising sum wrap
      pl[0] = 8'hFF; pl[1] = 8'h80; pl[2] = 8'h7F; pl[3] = 8'h01; pl[4] = 8'hAA; pl[5] = 8'h55;
      chk("model_sum6", {24'd0, psum(6)}, 32'hFE);
      run_frame(32'd6, 8'hFE, 6);

      // 3: length overflow by one byte
      run_frame(32'h0000_0801, 8'h00, 0);
      chk("t3_err", {31'd0, err}, 32'd1);

      // Exactly at capacity is accepted: only the length phase is checked here
      wr_count = 0;
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(8'(32'h0000_0800 >> (8 * k)), 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("cap_len_ok", {30'd0, err, in_ready}, 32'b01);
      // abort that frame by reset
      rst = 1'b0;
      #1;
      chk("cap_abort", {27'd0, in_ready, wr_en, cpu_hold, done, err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // 4: empty frame
      run_frame(32'd0, 8'h00, 0);
      chk("t4_done", {31'd0, done}, 32'd1);
      run_frame(32'd0, 8'h01, 0);
      chk("t4_err", {31'd0, err}, 32'd1);

      // 5: timeout after 2 payload bytes, then full resend
      pl[0] = 8'h13; pl[1] = 8'h05; pl[2] = 8'h00; pl[3] = 8'h00;
      wr_count = 0;
      send_frame(32'd4, 8'h18, 2);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("t5_not_yet", {31'd0, err}, 32'd0);
      @(negedge clk);
      chk("t5_err", {30'd0, err, cpu_hold}, 32'b11);
      chk("t5_writes", wr_count, 32'd2);
      run_frame(32'd4, 8'h18, 4);
      chk("t5_resend", {30'd0, done, cpu_hold}, 32'b10);

      // 6: reset mid-DATA after 3 bytes
      wr_count = 0;
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(8'(32'd4 >> (8 * k)), 1'b0, 0);
      for (int i = 0; i < 3; i++) send_byte(pl[i], 1'b1, i);
      #1;
      chk("t6_third_strobe", {19'd0, wr_en, wr_addr}, {19'd0, 1'b1, 12'd2});
      rst = 1'b0;
      due = 1'b0;
      #1;
      chk("t6_rst_out", {27'd0, in_ready, wr_en, cpu_hold, done, err}, 32'd0);
      chk("t6_rst_wr", {12'd0, wr_addr, wr_data}, 32'd0);
      chk("t6_writes", wr_count, 32'd2);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t6_ready_low", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      run_frame(32'd4, 8'h18, 4);
      chk("t6_done", {31'd0, done}, 32'd1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
